// File: rtl/regfile_bram_ctrl.sv
// regfile_bram_ctrl
//   Controller for the integer register file built on two true-dual-port,
//   read-first BRAM banks (bank 0 serves rs1, bank 1 serves rs2). After reset
//   it sweeps both banks with zeros. It then routes decode reads and
//   writeback writes to the banks, forces x0 to read as zero, and forwards a
//   writeback that lands on the same edge as a read. A read-first BRAM would
//   return the stale value in that case.
//
// Ports
//   clk_i, rst_i                      clock, async active-high reset
//   rd_req_i, rs1_addr_i, rs2_addr_i  decode read request and source indices
//   ready_o, init_done_o              high once the clear sweep is finished
//   rd_valid_o, rs1_data_o, rs2_data_o
//                                     read result, one cycle after accept
//   wb_en_i, wb_addr_i, wb_data_i     writeback port
//   bram_wr_en_o, bram_wr_addr_o, bram_wr_data_o
//                                     port A (write) of both banks
//   bram_rd_en_o, bram_rs1_addr_o, bram_rs2_addr_o
//                                     port B (read) of bank 0 / bank 1
//   bram_rs1_data_i, bram_rs2_data_i  port B read data, one-cycle latency

module regfile_bram_ctrl #(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_REGS   = 32,
    localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rd_req_i,
    input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
    output logic                  ready_o,
    output logic                  rd_valid_o,
    output logic [DATA_WIDTH-1:0] rs1_data_o,
    output logic [DATA_WIDTH-1:0] rs2_data_o,
    input  logic                  wb_en_i,
    input  logic [ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic                  init_done_o,
    output logic                  bram_wr_en_o,
    output logic [ADDR_WIDTH-1:0] bram_wr_addr_o,
    output logic [DATA_WIDTH-1:0] bram_wr_data_o,
    output logic                  bram_rd_en_o,
    output logic [ADDR_WIDTH-1:0] bram_rs1_addr_o,
    output logic [ADDR_WIDTH-1:0] bram_rs2_addr_o,
    input  logic [DATA_WIDTH-1:0] bram_rs1_data_i,
    input  logic [DATA_WIDTH-1:0] bram_rs2_data_i
);

    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_cnt;

    logic                  accept_p0;
    logic                  fwd1_p0;
    logic                  fwd2_p0;

    logic                  vld_p1;
    logic                  zero1_p1;
    logic                  zero2_p1;
    logic                  fwd1_p1;
    logic                  fwd2_p1;
    logic [DATA_WIDTH-1:0] fwd_data1_p1;
    logic [DATA_WIDTH-1:0] fwd_data2_p1;

    // ---- stage p0: request decode, BRAM address/write drive ----
    assign accept_p0 = rd_req_i && (state == RUN);

    // A writeback to the register being read on this edge would be missed by
    // the read-first BRAM, so capture it for the output mux instead.
    assign fwd1_p0 = wb_en_i && (wb_addr_i == rs1_addr_i) && (rs1_addr_i != '0);
    assign fwd2_p0 = wb_en_i && (wb_addr_i == rs2_addr_i) && (rs2_addr_i != '0);

    assign ready_o     = (state == RUN);
    assign init_done_o = (state == RUN);

    always_comb begin
        bram_wr_en_o   = 1'b1;
        bram_wr_addr_o = clr_cnt;
        bram_wr_data_o = '0;
        if (state == RUN) begin
            // Writes to x0 never reach the banks.
            bram_wr_en_o   = wb_en_i && (wb_addr_i != '0);
            bram_wr_addr_o = wb_addr_i;
            bram_wr_data_o = wb_data_i;
        end
    end

    assign bram_rd_en_o    = accept_p0;
    assign bram_rs1_addr_o = rs1_addr_i;
    assign bram_rs2_addr_o = rs2_addr_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= CLEAR;
            clr_cnt      <= '0;
            vld_p1       <= 1'b0;
            zero1_p1     <= 1'b1;
            zero2_p1     <= 1'b1;
            fwd1_p1      <= 1'b0;
            fwd2_p1      <= 1'b0;
            fwd_data1_p1 <= '0;
            fwd_data2_p1 <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST_ADDR) begin
                        state <= RUN;
                    end
                end
                RUN:     state <= RUN;
                default: state <= CLEAR;
            endcase

            vld_p1 <= accept_p0;

            // Without an accept the select flags hold, so the outputs keep
            // showing the last result while the BRAM holds its read data.
            if (accept_p0) begin
                zero1_p1 <= (rs1_addr_i == '0);
                zero2_p1 <= (rs2_addr_i == '0);
                fwd1_p1  <= fwd1_p0;
                fwd2_p1  <= fwd2_p0;
                if (fwd1_p0) begin
                    fwd_data1_p1 <= wb_data_i;
                end
                if (fwd2_p0) begin
                    fwd_data2_p1 <= wb_data_i;
                end
            end
        end
    end

    // ---- stage p1: result select (BRAM data arrives in this cycle) ----
    assign rd_valid_o = vld_p1;
    assign rs1_data_o = zero1_p1 ? '0 : (fwd1_p1 ? fwd_data1_p1 : bram_rs1_data_i);
    assign rs2_data_o = zero2_p1 ? '0 : (fwd2_p1 ? fwd_data2_p1 : bram_rs2_data_i);

endmodule

// File: doc/regfile_bram_ctrl.md
# regfile_bram_ctrl

- Controller for the integer register file. Sits directly upstream of two true-dual-port read-first BRAM banks: bank 0 serves rs1, bank 1 serves rs2.
- Zeroes both banks after reset, since BRAM contents cannot be reset.
- Routes decode-stage read requests and writeback writes to the banks, forces x0 to zero, and forwards same-cycle writebacks, because read-first BRAMs return stale data.

## Interface
- DATA_WIDTH, 32, register width.
- NUM_REGS, 32, number of architectural registers; power of two.
- ADDR_WIDTH, $clog2(NUM_REGS), derived; not to be overridden.
- clk_i  in  1  single clock, also drives both BRAM banks.
- rst_i  in  1  reset, asynchronous, active-high.
- rd_req_i  in  1  read request from decode; accepted when rd_req_i && ready_o.
- rs1_addr_i, rs2_addr_i  in  ADDR_WIDTH  source register indices.
- ready_o  out  1  high only in RUN.
- rd_valid_o  out  1  one-cycle pulse, one cycle after an accepted request.
- rs1_data_o, rs2_data_o  out  DATA_WIDTH  read results.
- wb_en_i  in  1  writeback strobe.
- wb_addr_i  in  ADDR_WIDTH  writeback register index.
- wb_data_i  in  DATA_WIDTH  writeback value.
- init_done_o  out  1  high in RUN.
- bram_wr_en_o  out  1  port A en/we of both banks (tied together).
- bram_wr_addr_o  out  ADDR_WIDTH  port A address, both banks.
- bram_wr_data_o  out  DATA_WIDTH  port A write data, both banks.
- bram_rd_en_o  out  1  port B en of both banks; port B we tied 0.
- bram_rs1_addr_o, bram_rs2_addr_o  out  ADDR_WIDTH  port B address, bank 0 / bank 1.
- bram_rs1_data_i, bram_rs2_data_i  in  DATA_WIDTH  port B read data, bank 0 / bank 1 (1-cycle latency; held while en low).

## Operation
**FSM states:** CLEAR, RUN. Reset forces CLEAR with clear counter = 0.

**CLEAR**
- bram_wr_en_o=1, bram_wr_addr_o=counter, bram_wr_data_o=0. This also applies while rst_i is held; repeated zero writes to address 0 are harmless.
- Counter increments on each edge after reset release.
- At counter==NUM_REGS-1, next state is RUN.
- Inputs are ignored: rd_req_i, and wb_en_i (writebacks are dropped).
- bram_rd_en_o=0.

**RUN**
- Write path is combinational:
  - bram_wr_en_o = wb_en_i && (wb_addr_i != 0).
  - bram_wr_addr_o = wb_addr_i; bram_wr_data_o = wb_data_i.
- Read path:
  - bram_rd_en_o = rd_req_i.
  - bram_rs1_addr_o = rs1_addr_i; bram_rs2_addr_o = rs2_addr_i.
- On accept, per source n, register:
  - zero_n = (rsn_addr_i == 0).
  - fwd_n = wb_en_i && wb_addr_i == rsn_addr_i && rsn_addr_i != 0; when set, fwd_data_n <= wb_data_i.
- Output mux: rsn_data_o = zero_n ? 0 : fwd_n ? fwd_data_n : bram_rsn_data_i.
- No accept: zero_n, fwd_n and fwd_data_n hold. Data outputs therefore hold the last result, even if that register is written afterwards.

**Reset mid-operation:** return to CLEAR, drop the pending rd_valid_o, re-zero all registers.

## Timing
- **Reset values:**
  - ready_o=0, init_done_o=0, rd_valid_o=0.
  - zero_1=zero_2=1, so rs1_data_o=rs2_data_o=0.
  - fwd_n=0, fwd_data_n=0.
  - bram_rd_en_o=0, bram_wr_en_o=1, bram_wr_addr_o=0, bram_wr_data_o=0.
- **Clear sequence:** edges 1..NUM_REGS after reset release write addresses 0..NUM_REGS-1. ready_o and init_done_o rise after edge NUM_REGS.
- **Read latency:** request accepted at edge k; rd_valid_o and data valid in cycle k+1. Back-to-back requests are accepted every cycle.
- **Write latency:**
  - Write at edge k is visible via BRAM to a read accepted at edge k+1 or later.
  - Write at edge k is visible via forwarding to a read accepted at edge k.
- **rd_valid_o** = registered (rd_req_i && ready_o); it is not gated by writes.
- **rst_i assertion** clears all registered outputs asynchronously, with no clock needed.

## Test plan
- Release reset → ready_o low for exactly 32 edges; bram_wr_en_o=1 with addr 0..31, data 0; then init_done_o=1 and ready_o=1.
- Write x5=0xDEADBEEF, next cycle request rs1=5, rs2=5 → one cycle later rd_valid_o=1 for one cycle, both outputs 0xDEADBEEF.
- Same cycle: write x7=0x12345678 and request rs1=7, rs2=3 (x3=0xA5A5A5A5) → rs1_data_o=0x12345678 (forwarded), rs2_data_o=0xA5A5A5A5.
- Write x0=0xFFFFFFFF → bram_wr_en_o=0. Request rs1=0, including with a same-cycle x0 write → rs1_data_o=0.
- After reading x5, no requests for 3 cycles while writing x5=0x1 → outputs stay 0xDEADBEEF, rd_valid_o=0.
- Assert rst_i mid-RUN with a request in flight → ready_o and rd_valid_o drop immediately. After release, 32 clear cycles; reading x5 returns 0.
